mem_port_arbiter: RTL

//  Shares the single-port unified memory between instruction fetch (IF) and load/store (LS) requesters.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and load/store (LS),
// serialising accesses as IDLE -> ISSUE -> WAIT -> RESP and covering the memory read latency.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int RR      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_ack,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              id_reg;          // 1 = LS owns the current access
  logic              we_reg;
  logic              last_grant_reg;  // 1 = LS was granted last
  logic              grant, win_ls, capture;
  logic              if_ack_next, ls_ack_next, if_rvalid_next, ls_rvalid_next;
  logic              mem_en_next, mem_we_next;
  logic [ADDR_W-3:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic [BE_W-1:0]   mem_be_next;

  // Byte offsets are the requester's business; only word addresses reach memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], ls_addr[1:0]};

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    grant          = 1'b0;
    win_ls         = 1'b0;
    capture        = 1'b0;
    if_ack_next    = 1'b0;
    ls_ack_next    = 1'b0;
    if_rvalid_next = 1'b0;
    ls_rvalid_next = 1'b0;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    mem_be_next    = mem_be;
    case (state_reg)
      IDLE: begin
        if (if_req || ls_req) begin
          grant  = 1'b1;
          // On a tie, round-robin favours whoever did not win last; otherwise LS wins.
          win_ls = ls_req && (!if_req || (RR == 0) || !last_grant_reg);
          state_next     = ISSUE;
          cnt_next       = 4'(MEM_LAT);
          mem_en_next    = 1'b1;
          mem_we_next    = win_ls && ls_we;
          mem_addr_next  = win_ls ? ls_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
          mem_wdata_next = (win_ls && ls_we) ? ls_wdata : '0;
          mem_be_next    = (win_ls && ls_we) ? ls_be : '1;
          if_ack_next    = !win_ls;
          ls_ack_next    = win_ls;
        end
      end
      ISSUE: begin
        cnt_next   = cnt_reg - 4'd1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          capture        = 1'b1;
          state_next     = RESP;
          if_rvalid_next = !id_reg;
          ls_rvalid_next = id_reg;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      id_reg         <= 1'b0;
      we_reg         <= 1'b0;
      last_grant_reg <= 1'b0;
      if_ack         <= 1'b0;
      ls_ack         <= 1'b0;
      if_rvalid      <= 1'b0;
      ls_rvalid      <= 1'b0;
      if_rdata       <= '0;
      ls_rdata       <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      busy           <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if_ack    <= if_ack_next;
      ls_ack    <= ls_ack_next;
      if_rvalid <= if_rvalid_next;
      ls_rvalid <= ls_rvalid_next;
      mem_en    <= mem_en_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      mem_be    <= mem_be_next;
      busy      <= (state_next != IDLE);
      if (grant) begin
        id_reg         <= win_ls;
        we_reg         <= mem_we_next;
        last_grant_reg <= win_ls;
      end
      // Each requester's rdata only changes alongside its own rvalid.
      if (capture) begin
        if (id_reg) ls_rdata <= we_reg ? '0 : mem_rdata;
        else        if_rdata <= mem_rdata;
      end
    end
  end

endmodule
